// File: rtl/cacheline_mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side signals around the line arbiter.
// master is the arbiter's view; slave is the caches-plus-memory view.
interface cacheline_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport master (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cacheline_mem_arbiter.sv
// Serialises I-cache and D-cache full-line transactions onto one memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise D-cache has fixed priority.
module cacheline_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    cacheline_mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    // owner/last_owner: 1 = D-cache, 0 = I-cache; op: 1 = write
    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic                  op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;

    logic i_req, d_req, grant_d;

    always_comb begin
        i_req = bus.i_read;
        d_req = bus.d_read | bus.d_write;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // on a tie, D wins only if I was served last
        grant_d = d_req & (~i_req | ~last_owner_q);
`else
        grant_d = d_req;
`endif
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (i_req | d_req) begin
                    owner_d = grant_d;
                    op_d    = grant_d & bus.d_write;
                    addr_d  = grant_d ? bus.d_addr : bus.i_addr;
                    wdata_d = (grant_d & bus.d_write) ? bus.d_wdata : '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_resp) begin
                    last_owner_d = owner_q;
                    // each side keeps its own copy so the idle side's data holds
                    if (owner_q) d_rdata_d = bus.mem_rdata;
                    else         i_rdata_d = bus.mem_rdata;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b0;
            op_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.mem_read  = (state_q == BUSY) & ~op_q;
    assign bus.mem_write = (state_q == BUSY) &  op_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_resp    = (state_q == RESP) & ~owner_q;
    assign bus.d_resp    = (state_q == RESP) &  owner_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Bench for cacheline_mem_arbiter: behavioural memory plus a transaction-order model.
module tb_cacheline_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    typedef logic [AW-1:0] addr_t;
    typedef logic [LW-1:0] line_t;
    typedef struct { addr_t addr; bit wr; line_t wdata; int start; } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    cacheline_mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus();
    cacheline_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    // memory contents seen by the memory model and by the reference model
    line_t mem[addr_t];
    line_t ref_mem[addr_t];
    function automatic line_t init_val(addr_t a); return {8{a ^ 32'h5A5A_0000}}; endfunction
    function automatic line_t mem_rd(addr_t a); return mem.exists(a) ? mem[a] : init_val(a); endfunction
    function automatic line_t ref_rd(addr_t a); return ref_mem.exists(a) ? ref_mem[a] : init_val(a); endfunction

    // model state: side served last (1 = D) and the value i_rdata should hold
    bit    m_last = 1'b0;
    line_t m_i_rdata = '0;

    // memory responder
    bit   in_cmd = 1'b0;
    bit   spur_req = 1'b0;
    int   wait_cnt = 0;
    int   mem_lat = 3;
    int   mresp_cyc = -10;
    txn_t cur;
    txn_t log_q[$];

    initial begin
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_resp) bus.mem_resp = 1'b0;
            else if (spur_req) begin
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = {8{32'hDEAD_BEEF}};
                spur_req      = 1'b0;
            end else if (rst || !(bus.mem_read || bus.mem_write)) in_cmd = 1'b0;
            else begin
                checks++;
                if (bus.mem_read && bus.mem_write) begin
                    errors++; $display("FAIL mem_excl: read=%0b write=%0b, required not both", bus.mem_read, bus.mem_write);
                end
                if (!in_cmd) begin
                    in_cmd = 1'b1; wait_cnt = 0;
                    cur.addr = bus.mem_addr; cur.wr = bus.mem_write; cur.wdata = bus.mem_wdata; cur.start = cyc;
                end else begin
                    checks++;
                    if (bus.mem_addr !== cur.addr || bus.mem_write !== cur.wr || bus.mem_wdata !== cur.wdata) begin
                        errors++; $display("FAIL mem_stable: addr=%h wr=%0b, required addr=%h wr=%0b", bus.mem_addr, bus.mem_write, cur.addr, cur.wr);
                    end
                end
                wait_cnt++;
                if (wait_cnt >= mem_lat) begin
                    if (cur.wr) begin mem[cur.addr] = cur.wdata; bus.mem_rdata = {8{$urandom}}; end
                    else bus.mem_rdata = mem_rd(cur.addr);
                    bus.mem_resp = 1'b1;
                    mresp_cyc = cyc;
                    log_q.push_back(cur);
                    in_cmd = 1'b0;
                end
            end
        end
    end

    // Present up to one I and one D request together and check service order, data, timing.
    task automatic run_pair(input bit ireq, input bit dreq, input bit dwr, input addr_t ia, input addr_t da, input line_t dw);
        bit    seq[2];
        int    n = 0;
        int    served = 0;
        int    t0;
        int    t_first = 0;
        bit    first_d;
        txn_t  e;
        txn_t  exp_q[$];
        line_t exp_i = '0;
        line_t exp_d = '0;
        if (ireq && dreq) first_d = RR ? !m_last : 1'b1;
        else              first_d = dreq;
        if (first_d && dreq)  begin seq[n] = 1'b1; n++; end
        if (ireq)             begin seq[n] = 1'b0; n++; end
        if (!first_d && dreq) begin seq[n] = 1'b1; n++; end
        for (int k = 0; k < n; k++) begin
            e.start = 0;
            if (seq[k]) begin
                e.addr = da; e.wr = dwr; e.wdata = dw;
                if (dwr) ref_mem[da] = dw; else exp_d = ref_rd(da);
            end else begin
                e.addr = ia; e.wr = 1'b0; e.wdata = '0;
                exp_i = ref_rd(ia); m_i_rdata = exp_i;
            end
            exp_q.push_back(e);
            m_last = seq[k];
        end

        log_q.delete();
        @(negedge clk);
        bus.i_read  = ireq;  bus.i_addr = ia;
        bus.d_write = dreq && dwr;
        bus.d_read  = dreq && (!dwr || ($urandom_range(0, 3) == 0));
        bus.d_addr  = da;    bus.d_wdata = dw;
        t0 = cyc;
        for (int c = 0; c < 300 && served < n; c++) begin
            @(negedge clk);
            if (bus.i_resp || bus.d_resp) begin
                checks++;
                if ((bus.i_resp && bus.d_resp) || bus.d_resp !== seq[served]) begin
                    errors++; $display("FAIL resp_order: i_resp=%0b d_resp=%0b, required d side=%0b", bus.i_resp, bus.d_resp, seq[served]);
                end
                checks++;
                if (cyc != mresp_cyc + 1) begin
                    errors++; $display("FAIL resp_timing: resp cycle %0d, required %0d", cyc, mresp_cyc + 1);
                end
                if (bus.i_resp) begin
                    checks++;
                    if (bus.i_rdata !== exp_i) begin errors++; $display("FAIL i_rdata: %h, required %h", bus.i_rdata, exp_i); end
                    bus.i_read = 1'b0;
                end
                if (bus.d_resp) begin
                    if (!dwr) begin
                        checks++;
                        if (bus.d_rdata !== exp_d) begin errors++; $display("FAIL d_rdata: %h, required %h", bus.d_rdata, exp_d); end
                    end
                    bus.d_read = 1'b0; bus.d_write = 1'b0;
                end
                if (served == 0) t_first = cyc;
                served++;
            end
        end
        bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
        checks++;
        if (served != n) begin errors++; $display("FAIL resp_timeout: served %0d, required %0d", served, n); end
        @(negedge clk);
        checks++;
        if (bus.i_resp || bus.d_resp) begin errors++; $display("FAIL resp_pulse: i=%0b d=%0b one cycle after RESP, required 0", bus.i_resp, bus.d_resp); end
        checks++;
        if (log_q.size() != n) begin
            errors++; $display("FAIL txn_count: %0d, required %0d", log_q.size(), n);
        end else begin
            for (int k = 0; k < n; k++) begin
                checks++;
                if (log_q[k].addr !== exp_q[k].addr || log_q[k].wr != exp_q[k].wr || (exp_q[k].wr && log_q[k].wdata !== exp_q[k].wdata)) begin
                    errors++; $display("FAIL txn%0d: addr=%h wr=%0b, required addr=%h wr=%0b", k, log_q[k].addr, log_q[k].wr, exp_q[k].addr, exp_q[k].wr);
                end
            end
            checks++;
            if (log_q[0].start != t0 + 1) begin errors++; $display("FAIL grant_latency: cmd at %0d, required %0d", log_q[0].start, t0 + 1); end
            if (n == 2) begin
                checks++;
                if (log_q[1].start != t_first + 2) begin errors++; $display("FAIL idle_gap: cmd at %0d, required %0d", log_q[1].start, t_first + 2); end
            end
        end
        checks++;
        if (bus.i_rdata !== m_i_rdata) begin errors++; $display("FAIL i_rdata_hold: %h, required %h", bus.i_rdata, m_i_rdata); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_read = 1'b0; bus.i_addr = '0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_read !== 1'b0)  begin errors++; $display("FAIL rst_mem_read: %b, required 0", bus.mem_read); end
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write: %b, required 0", bus.mem_write); end
        checks++; if (bus.mem_addr !== '0)    begin errors++; $display("FAIL rst_mem_addr: %h, required 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== '0)   begin errors++; $display("FAIL rst_mem_wdata: %h, required 0", bus.mem_wdata); end
        checks++; if (bus.i_resp !== 1'b0)    begin errors++; $display("FAIL rst_i_resp: %b, required 0", bus.i_resp); end
        checks++; if (bus.d_resp !== 1'b0)    begin errors++; $display("FAIL rst_d_resp: %b, required 0", bus.d_resp); end
        checks++; if (bus.i_rdata !== '0)     begin errors++; $display("FAIL rst_i_rdata: %h, required 0", bus.i_rdata); end
        checks++; if (bus.d_rdata !== '0)     begin errors++; $display("FAIL rst_d_rdata: %h, required 0", bus.d_rdata); end
        rst = 1'b0; m_last = 1'b0; m_i_rdata = '0;
    endtask

    task automatic test_i_read();
        mem[32'h60] = {64{4'hA}}; ref_mem[32'h60] = {64{4'hA}};
        mem_lat = 4;
        run_pair(1'b1, 1'b0, 1'b0, 32'h60, '0, '0);
    endtask

    task automatic test_d_write();
        mem_lat = 4;
        run_pair(1'b0, 1'b1, 1'b1, '0, 32'h1000, {64{4'h5}});
        run_pair(1'b0, 1'b1, 1'b0, '0, 32'h1000, '0);
    endtask

    task automatic test_tie();
        mem_lat = 2;
        run_pair(1'b1, 1'b1, 1'b0, 32'h40, 32'h80, '0);
        run_pair(1'b0, 1'b1, 1'b0, '0, 32'h100, '0);
        run_pair(1'b1, 1'b1, 1'b0, 32'h40, 32'h80, '0);
        run_pair(1'b1, 1'b1, 1'b1, 32'h180, 32'h180, {8{$urandom}});
    endtask

    task automatic test_addr_change();
        line_t exp;
        bit    done = 1'b0;
        mem_lat = 6;
        exp = ref_rd(32'h80);
        @(negedge clk);
        bus.d_read = 1'b1; bus.d_addr = 32'h80;
        m_last = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (c == 2) bus.d_addr = 32'hC0;
            if (bus.mem_read) begin
                checks++;
                if (bus.mem_addr !== 32'h80) begin errors++; $display("FAIL addr_hold: mem_addr=%h, required 00000080", bus.mem_addr); end
            end
            if (bus.d_resp) begin
                checks++;
                if (bus.d_rdata !== exp) begin errors++; $display("FAIL addr_change_data: %h, required %h", bus.d_rdata, exp); end
                bus.d_read = 1'b0; done = 1'b1;
            end
        end
        bus.d_read = 1'b0;
        checks++;
        if (!done) begin errors++; $display("FAIL addr_change_timeout: no d_resp, required one"); end
        @(negedge clk);
    endtask

    task automatic test_reset_busy();
        mem_lat = 30;
        @(negedge clk);
        bus.d_write = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = {8{$urandom}};
        repeat (3) @(negedge clk);
        checks++;
        if (bus.mem_write !== 1'b1) begin errors++; $display("FAIL busy_write: mem_write=%b, required 1", bus.mem_write); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            errors++; $display("FAIL rst_busy_mem: rd=%b wr=%b addr=%h, required all 0", bus.mem_read, bus.mem_write, bus.mem_addr);
        end
        checks++;
        if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin errors++; $display("FAIL rst_busy_resp: i=%b d=%b, required 0", bus.i_resp, bus.d_resp); end
        bus.d_write = 1'b0; rst = 1'b0; m_last = 1'b0; m_i_rdata = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.i_resp || bus.d_resp || bus.mem_read || bus.mem_write) begin
                errors++; $display("FAIL post_rst_quiet: i=%b d=%b rd=%b wr=%b, required 0", bus.i_resp, bus.d_resp, bus.mem_read, bus.mem_write);
            end
        end
        mem_lat = 3;
        run_pair(1'b0, 1'b1, 1'b1, '0, 32'h200, {8{$urandom}});
        run_pair(1'b1, 1'b0, 1'b0, 32'h200, '0, '0);
    endtask

    task automatic test_spurious();
        spur_req = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (bus.i_resp || bus.d_resp || bus.mem_read || bus.mem_write) begin
                errors++; $display("FAIL spurious: i=%b d=%b rd=%b wr=%b, required 0", bus.i_resp, bus.d_resp, bus.mem_read, bus.mem_write);
            end
        end
        checks++;
        if (bus.i_rdata !== m_i_rdata) begin errors++; $display("FAIL spurious_rdata: %h, required %h", bus.i_rdata, m_i_rdata); end
        mem_lat = 2;
        run_pair(1'b1, 1'b0, 1'b0, 32'h140, '0, '0);
    endtask

    task automatic test_random();
        bit    ir, dr, dw;
        addr_t ia, da;
        for (int it = 0; it < 40; it++) begin
            mem_lat = $urandom_range(1, 6);
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            if (!ir && !dr) dr = 1'b1;
            ia = $urandom_range(0, 7) << 6;
            da = $urandom_range(0, 7) << 6;
            run_pair(ir, dr, dw, ia, da, {8{$urandom}});
        end
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_tie();
        test_addr_change();
        test_reset_busy();
        test_spurious();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
